// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared types and scan-code constants for the PS/2 key event controller.
// Holds the prefix decoder states, the event record and the tracked-key table.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } kbd_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    // Keyboard status/response bytes that never describe a key
    localparam logic [7:0] NONKEY_BAT_OK = 8'hAA;
    localparam logic [7:0] NONKEY_ACK    = 8'hFA;
    localparam logic [7:0] NONKEY_ECHO   = 8'hEE;
    localparam logic [7:0] NONKEY_RESEND = 8'hFE;
    localparam logic [7:0] NONKEY_PAUSE  = 8'hE1;
    localparam logic [7:0] NONKEY_ERR0   = 8'h00;
    localparam logic [7:0] NONKEY_ERRF   = 8'hFF;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_SPACE = 4;
    localparam int KEY_ESC   = 5;
    localparam int NUM_KEYS  = 6;

    // Indexed by the KEY_* constants above
    localparam logic [NUM_KEYS-1:0][7:0] TRACK_CODE =
        {CODE_ESC, CODE_SPACE, CODE_RIGHT, CODE_LEFT, CODE_DOWN, CODE_UP};
    localparam logic [NUM_KEYS-1:0] TRACK_EXT = 6'b001111;

    typedef struct packed {
        logic       rpt;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    function automatic logic is_non_key(input logic [7:0] b);
        return (b == NONKEY_BAT_OK) || (b == NONKEY_ACK)    || (b == NONKEY_ECHO) ||
               (b == NONKEY_RESEND) || (b == NONKEY_PAUSE)  || (b == NONKEY_ERR0) ||
               (b == NONKEY_ERRF);
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out bundle of the PS/2 key event controller.
// slave is the controller side, master is the receiver/consumer side.
interface ps2_key_event_ctrl_if;
    logic        BYTE_VALID;
    logic [7:0]  BYTE_DATA;
    logic        BYTE_ERR;
    logic        EVT_VALID;
    logic        EVT_READY;
    logic [10:0] EVT_DATA;
    logic [5:0]  KEY_STATE;
    logic        OVERFLOW;
    logic        CLR_OVF;

    modport slave (
        input  BYTE_VALID, BYTE_DATA, BYTE_ERR, EVT_READY, CLR_OVF,
        output EVT_VALID, EVT_DATA, KEY_STATE, OVERFLOW
    );

    modport master (
        output BYTE_VALID, BYTE_DATA, BYTE_ERR, EVT_READY, CLR_OVF,
        input  EVT_VALID, EVT_DATA, KEY_STATE, OVERFLOW
    );
endinterface

// File: rtl/ps2_key_event_ctrl_fifo.sv
// First-word-fall-through event FIFO; the head entry is kept in its own
// register so dout is registered and stable while not popped.
module ps2_evt_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     CLK,
    input  logic     RST_N,
    input  logic     push,
    input  key_evt_t din,
    output logic     full,
    input  logic     pop,
    output logic     empty,
    output key_evt_t dout,
    output logic     drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    key_evt_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    key_evt_t          head_reg, head_next;
    logic              pop_ok, push_ok;

    assign full   = (count_reg == CW'(DEPTH));
    assign empty  = (count_reg == '0);
    assign pop_ok = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign dout    = head_reg;

    always_comb begin
        wr_ptr_next = push_ok ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = pop_ok  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
        head_next   = head_reg;
        if (pop_ok) begin
            if (count_reg == CW'(1)) begin
                if (push_ok)
                    head_next = din;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end else if (empty && push_ok) begin
            head_next = din;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan byte sequencer: resolves E0/F0 prefixes into key events,
// tracks the six navigation keys and queues events for the processor.
module ps2_key_event_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic               CLK,
    input logic               RST_N,
    ps2_key_event_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    kbd_state_e            state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [NUM_KEYS-1:0]   key_state_reg, key_state_next;
    logic                  overflow_reg, overflow_next;

    logic                  cur_ext, cur_brk;
    logic                  timeout_hit;
    logic                  push_evt;
    logic [NUM_KEYS-1:0]   key_hit;
    key_evt_t              evt_new;
    key_evt_t              fifo_dout;
    logic                  fifo_full, fifo_empty, fifo_drop, fifo_pop;

    assign cur_ext     = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0F0);
    assign cur_brk     = (state_reg == ST_GOT_F0) || (state_reg == ST_GOT_E0F0);
    assign timeout_hit = (state_reg != ST_IDLE) && (cnt_reg == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next = state_reg;
        push_evt   = 1'b0;
        if (bus.BYTE_VALID) begin
            if (bus.BYTE_ERR) begin
                state_next = ST_IDLE;
            end else if (bus.BYTE_DATA == PREFIX_EXT) begin
                state_next = ST_GOT_E0;
            end else if (bus.BYTE_DATA == PREFIX_BRK) begin
                // A repeated F0 leaves the sequence where it is
                case (state_reg)
                    ST_IDLE:   state_next = ST_GOT_F0;
                    ST_GOT_E0: state_next = ST_GOT_E0F0;
                    default:   state_next = state_reg;
                endcase
            end else if (is_non_key(bus.BYTE_DATA)) begin
                state_next = ST_IDLE;
            end else begin
                push_evt   = 1'b1;
                state_next = ST_IDLE;
            end
        end else if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (bus.BYTE_VALID || state_reg == ST_IDLE || timeout_hit)
            cnt_next = '0;
    end

    // Key identity needs both the code and the extended flag to match
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_keys
            assign key_hit[gi] = (bus.BYTE_DATA == TRACK_CODE[gi]) && (cur_ext == TRACK_EXT[gi]);
            assign key_state_next[gi] = (push_evt && key_hit[gi]) ? ~cur_brk : key_state_reg[gi];
        end
    endgenerate

    always_comb begin
        evt_new.rpt  = ~cur_brk & |(key_hit & key_state_reg);
        evt_new.ext  = cur_ext;
        evt_new.brk  = cur_brk;
        evt_new.code = bus.BYTE_DATA;
    end

    // A drop in the same cycle as a clear leaves the flag set
    always_comb begin
        overflow_next = overflow_reg;
        if (fifo_drop)
            overflow_next = 1'b1;
        else if (bus.CLR_OVF)
            overflow_next = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            key_state_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            key_state_reg <= key_state_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign fifo_pop = ~fifo_empty & bus.EVT_READY;

    ps2_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push_evt),
        .din   (evt_new),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .empty (fifo_empty),
        .dout  (fifo_dout),
        .drop  (fifo_drop)
    );

    assign bus.EVT_VALID = ~fifo_empty;
    assign bus.EVT_DATA  = fifo_dout;
    assign bus.KEY_STATE = key_state_reg;
    assign bus.OVERFLOW  = overflow_reg;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: byte-per-row vector table plus
// hand sequences for overflow, timeout boundary and asynchronous reset.
module tb_ps2_key_event_ctrl;
    localparam int DEPTH = 4;
    localparam int TOUT  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    ps2_key_event_ctrl_if bus();

    ps2_key_event_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic        exp_v;
        logic [10:0] exp_d;
        logic [5:0]  exp_k;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one byte for exactly one rising edge; call and return at a falling edge
    task automatic send(input logic [7:0] d, input logic e);
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_DATA  = d;
        bus.BYTE_ERR   = e;
        @(posedge clk);
        @(negedge clk);
        bus.BYTE_VALID = 1'b0;
        bus.BYTE_ERR   = 1'b0;
    endtask

    task automatic check_evt(input string name, input logic [10:0] d, input logic [5:0] k);
        check({name, "_valid"}, 32'(bus.EVT_VALID), 32'd1);
        check({name, "_data"},  32'(bus.EVT_DATA),  32'(d));
        check({name, "_keys"},  32'(bus.KEY_STATE), 32'(k));
        $display("[TB] %s: evt=%03h keys=%02h", name, bus.EVT_DATA, bus.KEY_STATE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] pop_exp [4];

        bus.BYTE_VALID = 1'b0;
        bus.BYTE_DATA  = 8'h00;
        bus.BYTE_ERR   = 1'b0;
        bus.EVT_READY  = 1'b1;
        bus.CLR_OVF    = 1'b0;

        tbl.push_back('{8'h29, 1'b0, 1'b1, 11'h029, 6'h10});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h10});
        tbl.push_back('{8'h29, 1'b0, 1'b1, 11'h129, 6'h00});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 11'h275, 6'h01});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h01});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 11'h675, 6'h01});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h01});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h01});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 11'h375, 6'h00});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 11'h075, 6'h00});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'h76, 1'b1, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'h76, 1'b0, 1'b1, 11'h076, 6'h20});
        tbl.push_back('{8'hAA, 1'b0, 1'b0, 11'h000, 6'h20});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h20});
        tbl.push_back('{8'hAA, 1'b0, 1'b0, 11'h000, 6'h20});
        tbl.push_back('{8'h74, 1'b0, 1'b1, 11'h074, 6'h20});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h20});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h20});
        tbl.push_back('{8'h76, 1'b0, 1'b1, 11'h176, 6'h00});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h00});
        tbl.push_back('{8'h6B, 1'b0, 1'b1, 11'h26B, 6'h04});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 11'h000, 6'h04});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h04});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 11'h000, 6'h04});
        tbl.push_back('{8'h6B, 1'b0, 1'b1, 11'h36B, 6'h00});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.EVT_VALID), 32'd0);
        check("rst_data",  32'(bus.EVT_DATA),  32'd0);
        check("rst_keys",  32'(bus.KEY_STATE), 32'd0);
        check("rst_ovf",   32'(bus.OVERFLOW),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: one byte per row, event (if any) checked one cycle later
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data, tbl[i].err);
            check($sformatf("row%0d_valid", i), 32'(bus.EVT_VALID), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v)
                check($sformatf("row%0d_data", i), 32'(bus.EVT_DATA), 32'(tbl[i].exp_d));
            check($sformatf("row%0d_keys", i), 32'(bus.KEY_STATE), 32'(tbl[i].exp_k));
            $display("[TB] row %0d: byte=%02h err=%0d valid=%0d evt=%03h keys=%02h",
                     i, tbl[i].data, tbl[i].err, bus.EVT_VALID, bus.EVT_DATA, bus.KEY_STATE);
        end
        @(negedge clk);
        check("drain_empty", 32'(bus.EVT_VALID), 32'd0);

        // Overflow: four retained, two dropped; drop beats a simultaneous clear
        bus.EVT_READY = 1'b0;
        for (int i = 0; i < 6; i++)
            send(8'h1C + 8'(i), 1'b0);
        check("ovf_set",  32'(bus.OVERFLOW), 32'd1);
        check("ovf_head", 32'(bus.EVT_DATA), 32'h01C);
        bus.CLR_OVF = 1'b1;
        send(8'h22, 1'b0);
        bus.CLR_OVF = 1'b0;
        check("ovf_set_wins", 32'(bus.OVERFLOW), 32'd1);
        bus.CLR_OVF = 1'b1;
        @(negedge clk);
        bus.CLR_OVF = 1'b0;
        check("ovf_clr",     32'(bus.OVERFLOW), 32'd0);
        check("head_stable", 32'(bus.EVT_DATA), 32'h01C);
        $display("[TB] overflow: ovf=%0d head=%03h", bus.OVERFLOW, bus.EVT_DATA);

        // Full FIFO with pop in the same cycle accepts the push
        bus.EVT_READY = 1'b1;
        send(8'h23, 1'b0);
        check("full_pop_push_ovf", 32'(bus.OVERFLOW), 32'd0);
        pop_exp[0] = 11'h01D;
        pop_exp[1] = 11'h01E;
        pop_exp[2] = 11'h01F;
        pop_exp[3] = 11'h023;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pop%0d_valid", k), 32'(bus.EVT_VALID), 32'd1);
            check($sformatf("pop%0d_data", k),  32'(bus.EVT_DATA),  32'(pop_exp[k]));
            $display("[TB] pop %0d: evt=%03h", k, bus.EVT_DATA);
            @(negedge clk);
        end
        check("pop_empty", 32'(bus.EVT_VALID), 32'd0);

        // Timeout boundary: byte on the timeout cycle still completes the E0 sequence
        send(8'hE0, 1'b0);
        repeat (TOUT - 1) @(negedge clk);
        send(8'h6B, 1'b0);
        check_evt("tout_edge", 11'h26B, 6'h04);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        check_evt("tout_clear", 11'h36B, 6'h00);
        // One cycle later the prefix has been abandoned
        send(8'hE0, 1'b0);
        repeat (TOUT) @(negedge clk);
        send(8'h6B, 1'b0);
        check_evt("tout_expired", 11'h06B, 6'h00);
        @(negedge clk);

        // Asynchronous reset mid-sequence with a non-empty FIFO
        bus.EVT_READY = 1'b0;
        send(8'h29, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        check_evt("pre_rst", 11'h029, 6'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.EVT_VALID), 32'd0);
        check("async_rst_data",  32'(bus.EVT_DATA),  32'd0);
        check("async_rst_keys",  32'(bus.KEY_STATE), 32'd0);
        $display("[TB] async reset: valid=%0d keys=%02h", bus.EVT_VALID, bus.KEY_STATE);
        @(negedge clk);
        rst_n = 1'b1;
        bus.EVT_READY = 1'b1;
        @(negedge clk);
        send(8'h74, 1'b0);
        check_evt("post_rst", 11'h074, 6'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
